// File: rtl/derotator_pkg.sv
// derotator_pkg: shared types and constants for the derotator block.
//   state_t       : FSM states (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH : default data width
//   DIR_RIGHT/LEFT: encoding of the original rotation direction (lr input)
package derotator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int   DEFAULT_WIDTH = 32;
    localparam logic DIR_RIGHT     = 1'b0;
    localparam logic DIR_LEFT      = 1'b1;

endpackage

// File: rtl/derotator_rot.sv
// rot_stage: one combinational rotate stage of the derotator.
// Ports:
//   i_word  - word to rotate
//   i_stage - stage index k; rotation amount is 2^k
//   i_dir   - original direction; the stage rotates the opposite way
//             (DIR_RIGHT -> rotate left, DIR_LEFT -> rotate right)
//   i_en    - 1: rotate, 0: pass i_word through
//   o_word  - result
module rot_stage
    import derotator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [SAW-1:0]   i_stage,
    input  logic             i_dir,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_word
);

    // Amount is 2^k with k <= SAW-1, so it lies in [1, WIDTH/2] and the
    // complementary shift (WIDTH - amount) never reaches zero or WIDTH.
    int w_sh;
    assign w_sh = 1 << i_stage;

    always_comb begin
        o_word = i_word;
        if (i_en) begin
            if (i_dir == DIR_RIGHT)
                o_word = (i_word << w_sh) | (i_word >> (WIDTH - w_sh));
            else
                o_word = (i_word >> w_sh) | (i_word << (WIDTH - w_sh));
        end
    end

endmodule

// File: rtl/derotator.sv
// derotator: restores a word that was rotated by shiftAmt in direction lr.
// The rotation is undone one binary stage per SHIFT cycle, stage k handling
// bit k of shiftAmt (rotate by 2^k the opposite way).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid / in_ready  - job handshake (data, shiftAmt, lr captured)
//   out_valid / out_ready- result handshake, y holds the restored word
// Optional build macro DEROTATOR_STAGE_SKIP_EN: stages whose shiftAmt bit
// is 0 are skipped, so latency becomes popcount(shiftAmt)+1 edges.
module derotator
    import derotator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [SAW-1:0]   shiftAmt,
    input  logic             lr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_work, w_rot;
    logic [SAW-1:0]   r_cnt, r_amt;
    logic             r_lr;
    logic [SAW-1:0]   w_cnt_init, w_cnt_next;
    logic             w_en, w_last, w_skip_all;

    // Enable of the current stage = captured shiftAmt bit at r_cnt.
    assign w_en = |(r_amt & (SAW'(1) << r_cnt));

`ifdef DEROTATOR_STAGE_SKIP_EN
    // Lowest set bit of amt at index >= from; MSB of the result = found.
    function automatic logic [SAW:0] f_next_set(input logic [SAW-1:0] amt,
                                                input int from);
        logic [SAW:0] res;
        res = '0;
        for (int i = SAW - 1; i >= 0; i--)
            if (amt[i] && i >= from) res = {1'b1, SAW'(i)};
        return res;
    endfunction

    logic [SAW:0] w_scan_acc, w_scan_run;
    assign w_scan_acc = f_next_set(shiftAmt, 0);
    assign w_scan_run = f_next_set(r_amt, int'(r_cnt) + 1);
    assign w_cnt_init = w_scan_acc[SAW-1:0];
    assign w_cnt_next = w_scan_run[SAW-1:0];
    assign w_last     = !w_scan_run[SAW];
    assign w_skip_all = !w_scan_acc[SAW];
`else
    assign w_cnt_init = '0;
    assign w_cnt_next = r_cnt + SAW'(1);
    assign w_last     = (r_cnt == SAW'(SAW - 1));
    assign w_skip_all = 1'b0;
`endif

    rot_stage #(.WIDTH(WIDTH), .SAW(SAW)) u_rot (
        .i_word  (r_work),
        .i_stage (r_cnt),
        .i_dir   (r_lr),
        .i_en    (w_en),
        .o_word  (w_rot)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_amt   <= '0;
            r_lr    <= DIR_RIGHT;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= data;
                        r_amt  <= shiftAmt;
                        r_lr   <= lr;
                        r_cnt  <= w_cnt_init;
                    end
                end
                SHIFT: begin
                    r_work <= w_rot;
                    r_cnt  <= w_cnt_next;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_skip_all ? DONE : SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        y         = r_work;
    end

endmodule

// File: tb/tb_derotator.sv
module tb_derotator;
    localparam int W = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         reset, in_valid, lr, out_ready;
    logic [W-1:0] data;
    logic [S-1:0] shiftAmt;
    logic         in_ready, out_valid;
    logic [W-1:0] y;

    int n_vec = 0;
    int n_bad = 0;

    derotator #(.WIDTH(W), .SAW(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .shiftAmt(shiftAmt), .lr(lr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Restore: undo a rotation of d by a in direction l (0 = right, 1 = left).
    function automatic logic [W-1:0] restore(input logic [W-1:0] d, input int a, input logic l);
        int s;
        s = a % W;
        if (s == 0) return d;
        if (l == 1'b0) return (d << s) | (d >> (W - s));
        return (d >> s) | (d << (W - s));
    endfunction

    function automatic int latency(input logic [S-1:0] a);
`ifdef DEROTATOR_STAGE_SKIP_EN
        return $countones(a) + 1;
`else
        return S + 1;
`endif
    endfunction

    // Transaction-level model: busy flag, edges since accept, expected result.
    bit           m_known = 0, m_busy = 0;
    int           m_n, m_lat;
    logic [W-1:0] m_res, m_y;

    always @(posedge clk) begin
        if (reset) begin
            m_known = 1; m_busy = 0; m_y = '0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1; m_n = 1;
                    m_lat = latency(shiftAmt);
                    m_res = restore(data, int'(shiftAmt), lr);
                end
            end else if (m_n >= m_lat) begin
                if (out_ready) begin m_busy = 0; m_y = m_res; end
            end else begin
                m_n++;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready", W'(in_ready), W'(!m_busy));
            chk("out_valid", W'(out_valid), W'(m_busy && m_n >= m_lat));
            if (!m_busy) chk("y_idle", y, m_y);
            else if (m_n >= m_lat) chk("y_done", y, m_res);
        end
    end

    // Directed job with literal expected result and latency.
    task automatic job(input logic [W-1:0] d, input logic [S-1:0] a, input logic l,
                       input logic [W-1:0] ey, input int elat);
        int n;
        bit seen;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        #1;
        out_ready = 1; in_valid = 1; data = d; shiftAmt = a; lr = l;
        @(posedge clk); #1;
        in_valid = 0; data = $urandom; shiftAmt = S'($urandom); lr = ~l;
        n = 1; seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
            @(posedge clk);
            n++;
        end
        if (!seen) chk("timeout", 0, 1);
        chk("latency", W'(n), W'(elat));
        chk("y_literal", y, ey);
        @(posedge clk);
    endtask

    initial begin
        logic [W-1:0] rec;
        bit seen;
        reset = 1; in_valid = 0; data = '0; shiftAmt = '0; lr = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_y", y, 0);
        #1 reset = 0;

`ifdef DEROTATOR_STAGE_SKIP_EN
        job(32'h2211C084, 5'd1, 1'b0, 32'h44238108, 2);
        job(32'h81084423, 5'd16, 1'b1, 32'h44238108, 2);
        job(32'h84702108, 5'd5, 1'b1, 32'h44238108, 3);
        job(32'h44238108, 5'd0, 1'b0, 32'h44238108, 1);
`else
        job(32'h2211C084, 5'd1, 1'b0, 32'h44238108, 6);
        job(32'h81084423, 5'd16, 1'b1, 32'h44238108, 6);
        job(32'h84702108, 5'd5, 1'b1, 32'h44238108, 6);
        job(32'h44238108, 5'd0, 1'b0, 32'h44238108, 6);
`endif

        // Backpressure in DONE: output stable, new in_valid ignored.
        @(negedge clk); #1;
        out_ready = 0; in_valid = 1; data = 32'hDEADBEEF; shiftAmt = 5'd7; lr = 0;
        @(posedge clk); #1 in_valid = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
        end
        if (!seen) chk("bp_timeout", 0, 1);
        chk("bp_y", y, restore(32'hDEADBEEF, 7, 1'b0));
        rec = y;
        for (int i = 0; i < 3; i++) begin
            #1 in_valid = 1; data = $urandom; shiftAmt = S'($urandom);
            @(posedge clk); @(negedge clk);
            chk("bp_hold_valid", W'(out_valid), 1);
            chk("bp_hold_ready", W'(in_ready), 0);
            chk("bp_hold_y", y, rec);
        end
        #1 out_ready = 1;
        @(posedge clk); @(negedge clk);
        chk("bp_release_in_ready", W'(in_ready), 1);
        chk("bp_release_out_valid", W'(out_valid), 0);
        @(posedge clk); #1 in_valid = 0;
        repeat (10) @(posedge clk);

        // Reset on the 3rd SHIFT cycle aborts the job.
        @(negedge clk); #1;
        in_valid = 1; data = 32'h12345678; shiftAmt = 5'h1F; lr = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1;
        @(posedge clk); @(negedge clk);
        chk("abort_in_ready", W'(in_ready), 1);
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_y", y, 0);
        #1 reset = 0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_output", W'(out_valid), 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            data      = $urandom;
            shiftAmt  = S'($urandom);
            lr        = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk); #1;
        reset = 0; in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/derotator.md
DEROTATOR -- requirements
Module: derotator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (power of two, >= 4).
REQ-002 SHALL have parameter SAW, default $clog2(WIDTH), shiftAmt width and number of rotate stages.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers data/shiftAmt/lr.
REQ-006 SHALL have port in_ready  output  1  block can accept a job.
REQ-007 SHALL have port data  input  WIDTH  rotated word to be restored.
REQ-008 SHALL have port shiftAmt  input  SAW  rotation amount originally applied.
REQ-009 SHALL have port lr  input  1  original direction: 0 = data was rotated right, 1 = data was rotated left.
REQ-010 SHALL have port out_valid  output  1  y holds a restored word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts y.
REQ-012 SHALL have port y  output  WIDTH  restored (de-rotated) word.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept a job on an edge with in_valid && in_ready: capture data into the work register, capture shiftAmt and lr, clear stage counter to 0, go to SHIFT.
REQ-016 SHALL, in SHIFT, process stage k = stage counter: if shiftAmt[k]=1, rotate the work register by 2^k opposite to lr (lr=0 -> rotate left, lr=1 -> rotate right); otherwise hold it.
REQ-017 SHALL increment the stage counter each SHIFT cycle and go to DONE after stage SAW-1.
REQ-018 SHALL, without STAGE_SKIP_EN, assert out_valid exactly SAW+1 rising edges after and including the accepting edge (6 for WIDTH=32), regardless of shiftAmt.
REQ-019 SHALL present y = work register; y SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL, in DONE, return to IDLE on the edge with out_ready=1; in_valid SHALL be ignored outside IDLE (no bypass, no overlap).
REQ-021 SHALL treat rotation modulo WIDTH; shiftAmt=0 returns y == data.
REQ-022 SHALL ignore changes on data/shiftAmt/lr after the accepting edge.

Reset
REQ-023 SHALL, on any edge with reset=1, enter IDLE, clear work register, stage counter, captured shiftAmt/lr to 0, regardless of current state.
REQ-024 SHALL drive out_valid=0, in_ready=1, y=0 in the cycle after reset; a job in flight at reset is discarded with no output.
REQ-025 reset SHALL take priority over any handshake on the same edge.

Configuration
REQ-026 SHALL honour macro DEROTATOR_STAGE_SKIP_EN: when defined, the stage counter jumps to the next stage whose shiftAmt bit is 1 (and to DONE if none remain), and a job with shiftAmt=0 goes IDLE->DONE on the accepting edge.
REQ-027 SHALL, with the macro defined, assert out_valid popcount(shiftAmt)+1 edges after and including the accepting edge; y values SHALL be identical to the macro-undefined build.

Structure
REQ-028 SHALL place the state enum (IDLE/SHIFT/DONE), default WIDTH constant, and direction constants (DIR_RIGHT=0, DIR_LEFT=1) in package derotator_pkg.
REQ-029 SHALL use one combinational sub-module rot_stage (inputs word, stage index, direction, enable; output rotated word) instantiated once.

Verification
REQ-030 SHALL cover: data=32'h2211C084, shiftAmt=1, lr=0 -> y=32'h44238108, out_valid on 6th edge (no macro).
REQ-031 SHALL cover: data=32'h81084423, shiftAmt=16, lr=1 -> y=32'h44238108; with macro, out_valid on 2nd edge.
REQ-032 SHALL cover: data=32'h84702108, shiftAmt=5, lr=1 -> y=32'h44238108; with macro, out_valid on 3rd edge.
REQ-033 SHALL cover: out_ready held 0 for 3 cycles in DONE -> y and out_valid stable, in_ready=0, new in_valid pulse ignored; job accepted only after out_ready handshake.
REQ-034 SHALL cover: reset=1 on 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, y=0; no output for aborted job.
REQ-035 SHALL cover: shiftAmt=0, data=32'h44238108 -> y=32'h44238108 (6 edges without macro, 1 with).
